// File: rtl/demux4_seq.sv
// Registered 1-to-4 demultiplexer: one input stream steered to four channels,
// each with a one-entry holding register and its own valid/ready handshake.

module demux4_chan #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             acc
);
  // A full slot being drained this cycle can take new data in the same cycle.
  assign acc = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

module demux4_seq #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel1,
  input  logic             sel0,
  input  logic             auto_en,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             valid0,
  output logic             valid1,
  output logic             valid2,
  output logic             valid3,
  input  logic             ready0,
  input  logic             ready1,
  input  logic             ready2,
  input  logic             ready3,
  output logic [1:0]       ptr
);
  localparam int NUM_LANES = 4;

  logic [1:0]                      s;
  logic                            xfer;
  logic [NUM_LANES-1:0]            acc, load, vld, rdy;
  logic [NUM_LANES-1:0][WIDTH-1:0] dat;

  assign s        = auto_en ? ptr : {sel1, sel0};
  assign in_ready = acc[s];
  assign xfer     = in_valid && in_ready;
  assign rdy      = {ready3, ready2, ready1, ready0};

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign load[k] = xfer && (s == 2'(k));

    demux4_chan #(.WIDTH(WIDTH)) u_chan (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .din   (in),
      .ready (rdy[k]),
      .dout  (dat[k]),
      .valid (vld[k]),
      .acc   (acc[k])
    );
  end

  assign {out3, out2, out1, out0}         = dat;
  assign {valid3, valid2, valid1, valid0} = vld;

  // Pointer only moves on accepted transfers made in auto mode.
  always_ff @(posedge clk) begin
    if (rst)                 ptr <= 2'd0;
    else if (xfer && auto_en) ptr <= ptr + 2'd1;
  end
endmodule

// File: tb/tb_demux4_seq.sv
// Bench for demux4_seq: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural channel model.

module tb_demux4_seq;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             sel1 = 1'b0, sel0 = 1'b0, auto_en = 1'b0;
  logic [WIDTH-1:0] out0, out1, out2, out3;
  logic             valid0, valid1, valid2, valid3;
  logic [3:0]       rdy = 4'hF;
  logic [1:0]       ptr;

  demux4_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .sel1(sel1), .sel0(sel0), .auto_en(auto_en),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .ready0(rdy[0]), .ready1(rdy[1]), .ready2(rdy[2]), .ready3(rdy[3]),
    .ptr(ptr)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] o [4];
  logic [3:0]       v;
  assign o[0] = out0;
  assign o[1] = out1;
  assign o[2] = out2;
  assign o[3] = out3;
  assign v    = {valid3, valid2, valid1, valid0};

  // Behavioural model: four holding slots and a wrap-around pointer.
  logic [WIDTH-1:0] m_out [4];
  logic             m_valid [4];
  int               m_ptr;
  bit               model_ok = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cur_sel();
    return auto_en ? m_ptr : int'({sel1, sel0});
  endfunction

  function automatic bit model_in_ready();
    int t;
    t = cur_sel();
    return !m_valid[t] || rdy[t];
  endfunction

  // Advance one clock; update the model from the inputs seen at that edge.
  task automatic step();
    int  t;
    bit  x;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin m_out[k] = '0; m_valid[k] = 0; end
      m_ptr = 0;
    end else begin
      t = cur_sel();
      x = in_valid && model_in_ready();
      for (int k = 0; k < 4; k++) if (m_valid[k] && rdy[k]) m_valid[k] = 0;
      if (x) begin
        m_out[t]   = in;
        m_valid[t] = 1;
        if (auto_en) m_ptr = (m_ptr + 1) % 4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic ae, input int sel);
    in = d; auto_en = ae; {sel1, sel0} = 2'(sel); in_valid = 1'b1;
  endtask

  // Continuous comparison against the model whenever outputs are defined.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("model valid%0d", k), 32'(v[k]), 32'(m_valid[k]));
        chk($sformatf("model out%0d", k), 32'(o[k]), 32'(m_out[k]));
      end
      chk("model ptr", 32'(ptr), 32'(m_ptr));
      chk("model in_ready", 32'(in_ready), 32'(model_in_ready()));
    end
  end

  initial begin : main
    logic [WIDTH-1:0] rr [5];
    rr[0] = 8'd1; rr[1] = 8'd0; rr[2] = 8'd1; rr[3] = 8'd1; rr[4] = 8'd0;

    // Reset state
    #2;
    do_reset();
    model_ok = 1;
    chk("reset valids", 32'(v), 32'h0);
    chk("reset ptr", 32'(ptr), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);
    chk("reset out3", 32'(out3), 32'h0);

    // Manual routing
    rdy = 4'hF;
    send(8'd1, 1'b0, 2); step();
    chk("manual valids", 32'(v), 32'h4);
    chk("manual out2", 32'(out2), 32'h1);
    in_valid = 1'b0; step();
    chk("manual drain valid2", 32'(valid2), 32'h0);
    chk("manual hold out2", 32'(out2), 32'h1);

    // Backpressure with fill-while-drain
    rdy = 4'b1101;
    send(8'hA5, 1'b0, 1); step();
    chk("bp first valid1", 32'(valid1), 32'h1);
    chk("bp first out1", 32'(out1), 32'hA5);
    in = 8'h5A;
    chk("bp stalled in_ready", 32'(in_ready), 32'h0);
    step();
    chk("bp held out1", 32'(out1), 32'hA5);
    rdy = 4'hF; #1;
    chk("bp drain in_ready", 32'(in_ready), 32'h1);
    step();
    chk("bp refill valid1", 32'(valid1), 32'h1);
    chk("bp refill out1", 32'(out1), 32'h5A);

    // Independence: channel 3 stuck full, channel 0 still loads
    rdy = 4'b0111;
    send(8'h33, 1'b0, 3); step();
    send(8'h44, 1'b0, 0); #1;
    chk("indep in_ready", 32'(in_ready), 32'h1);
    step();
    chk("indep out0", 32'(out0), 32'h44);
    chk("indep valid3", 32'(valid3), 32'h1);
    chk("indep out3", 32'(out3), 32'h33);
    in_valid = 1'b0;

    // Round-robin wrap
    do_reset();
    rdy = 4'hF;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr ptr before %0d", i), 32'(ptr), 32'(i % 4));
      send(rr[i], 1'b1, 0); step();
      chk($sformatf("rr load %0d", i), 32'(o[i % 4]), 32'(rr[i]));
      chk($sformatf("rr valid %0d", i), 32'(v[i % 4]), 32'h1);
    end
    chk("rr ptr after wrap", 32'(ptr), 32'h1);
    send(8'h11, 1'b1, 0); step();
    chk("rr ptr 2", 32'(ptr), 32'h2);
    rdy = 4'b1011;
    send(8'h22, 1'b0, 2); step();
    send(8'h23, 1'b1, 0); #1;
    chk("rr stall in_ready", 32'(in_ready), 32'h0);
    step();
    chk("rr stall ptr", 32'(ptr), 32'h2);
    chk("rr stall out2", 32'(out2), 32'h22);

    // Reset mid-operation discards the concurrent transfer
    in_valid = 1'b0;
    do_reset();
    rdy = 4'h0;
    for (int i = 0; i < 3; i++) begin send(8'(8'h60 + i), 1'b1, 0); step(); end
    send(8'h63, 1'b0, 3); step();
    chk("pre-reset valids", 32'(v), 32'hF);
    chk("pre-reset ptr", 32'(ptr), 32'h3);
    rdy = 4'h8;
    send(8'h99, 1'b1, 0); rst = 1'b1; step(); rst = 1'b0; in_valid = 1'b0;
    chk("mid-reset valids", 32'(v), 32'h0);
    chk("mid-reset outs", {out3, out2, out1, out0}, 32'h0);
    chk("mid-reset ptr", 32'(ptr), 32'h0);

    // Mode switch keeps the pointer
    rdy = 4'hF;
    for (int i = 0; i < 3; i++) begin send(8'(8'h70 + i), 1'b1, 0); step(); end
    send(8'h77, 1'b0, 0); step();
    chk("mode manual out0", 32'(out0), 32'h77);
    chk("mode manual ptr", 32'(ptr), 32'h3);
    send(8'h88, 1'b1, 1); step();
    chk("mode auto out3", 32'(out3), 32'h88);
    chk("mode auto ptr", 32'(ptr), 32'h0);

    // Randomized run
    for (int c = 0; c < 3000; c++) begin
      in       = 8'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      {sel1, sel0} = 2'($urandom);
      auto_en  = ($urandom_range(0, 2) != 0);
      rdy      = 4'($urandom);
      rst      = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0;
    step();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
